// File: rtl/override_ctrl.sv
// -----------------------------------------------------------------------------
// override_ctrl
//
// Purpose:
//   Forces a value onto a target register for a bounded number of cycles.
//   A request is accepted only when the controller is idle. The forced value
//   is then held for max(req_len, HOLD_MIN) cycles. An early release request
//   is honoured only once HOLD_MIN forced cycles have been served. After the
//   override ends, done pulses for one cycle and the block returns to idle.
//
// Parameters:
//   WIDTH     width of the forced value
//   HOLD_MIN  minimum forced cycles per request (1..255)
//
// Optional feature:
//   OVERRIDE_CTRL_CHECK_EN  when defined, tgt_q is compared against force_val
//                           on every HOLD cycle. A mismatch sets the sticky
//                           err flag, which is cleared only by rst. When not
//                           defined, err is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req_valid  in   force request offered
//   req_ready  out  controller is idle and will accept a request
//   req_val    in   value to force (WIDTH bits)
//   req_len    in   requested hold length in cycles (0 means HOLD_MIN)
//   rel_req    in   early release request
//   tgt_q      in   target register readback (WIDTH bits)
//   force_en   out  override asserted on the target
//   force_val  out  value driven while force_en is high
//   busy       out  controller is not idle
//   done       out  one-cycle pulse when the override is released
//   err        out  sticky readback mismatch flag
// -----------------------------------------------------------------------------
module override_ctrl #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_val,
  input  logic [7:0]       req_len,
  input  logic             rel_req,
  input  logic [WIDTH-1:0] tgt_q,
  output logic             force_en,
  output logic [WIDTH-1:0] force_val,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [7:0] HOLD_MIN_L = 8'(HOLD_MIN);

  typedef enum logic [1:0] {
    IDLE,
    FORCE,
    HOLD,
    RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic [7:0]       r_elapsed;
  logic [7:0]       w_elapsed_nxt;
  logic [WIDTH-1:0] r_force_val;
  logic [WIDTH-1:0] w_force_val_nxt;
  logic             r_ready;
  logic             r_force_en;
  logic             r_busy;
  logic             r_done;
  logic             w_handshake;
  logic             w_rel_ok;

  // req_ready is registered and high only in IDLE, so a handshake needs
  // no extra state check.
  assign w_handshake = req_valid & r_ready;

  // r_elapsed holds the index of the current forced cycle, starting at 1.
  // An early release is allowed once HOLD_MIN forced cycles are served.
  assign w_rel_ok = rel_req && (r_elapsed >= HOLD_MIN_L);

  // Next-state logic. r_cnt counts the forced cycles still to go,
  // including the current one. When it reaches 1, this is the last
  // forced cycle. FORCE and HOLD share the same countdown, so the total
  // number of force_en cycles equals the value loaded at the handshake.
  // r_elapsed never exceeds 255, because the countdown ends first.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_elapsed_nxt   = r_elapsed;
    w_force_val_nxt = r_force_val;
    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_force_val_nxt = req_val;
          w_cnt_nxt       = (req_len < HOLD_MIN_L) ? HOLD_MIN_L : req_len;
          w_elapsed_nxt   = 8'd1;
          w_state_nxt     = FORCE;
        end
      end
      FORCE, HOLD: begin
        if ((r_cnt <= 8'd1) || w_rel_ok) begin
          w_state_nxt = RELEASE;
        end else begin
          w_cnt_nxt     = r_cnt - 8'd1;
          w_elapsed_nxt = r_elapsed + 8'd1;
          w_state_nxt   = HOLD;
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register. The outputs are registered from the next state, so
  // each output lines up exactly with the state it belongs to. A reset
  // mid-override clears everything at once, so no done pulse is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_elapsed   <= 8'd0;
      r_force_val <= '0;
      r_ready     <= 1'b1;
      r_force_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_elapsed   <= w_elapsed_nxt;
      r_force_val <= w_force_val_nxt;
      r_ready     <= (w_state_nxt == IDLE);
      r_force_en  <= (w_state_nxt == FORCE) || (w_state_nxt == HOLD);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == RELEASE);
    end
  end

`ifdef OVERRIDE_CTRL_CHECK_EN
  logic r_err;

  // Readback check. The FORCE cycle is skipped, because the target may not
  // yet reflect the override. The flag stays set until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == HOLD) && (tgt_q != r_force_val)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_tgt;

  // tgt_q has no function in this build. It is folded into a
  // deliberately unused net.
  assign w_unused_tgt = ^tgt_q;
  assign err          = 1'b0;
`endif

  assign req_ready = r_ready;
  assign force_en  = r_force_en;
  assign force_val = r_force_val;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_override_ctrl.sv
// -----------------------------------------------------------------------------
// tb_override_ctrl
//
// Self-checking bench for override_ctrl (WIDTH=8, HOLD_MIN=4).
//
// A behavioural model tracks what every output must be, one cycle at a time.
// Its terms are a request's forced-cycle index and its total length.
// A compare process checks all DUT outputs against the model on every
// negative edge once reset has been applied.
//
// Directed scenarios:
//   - basic request
//   - short requests
//   - maximum length
//   - early release
//   - reset mid-hold
//   - readback check
//   - back-to-back requests
//
// Literal expectations pin the run lengths, done pulses and forced values.
// Macro OVERRIDE_CTRL_CHECK_EN selects the expected err behaviour.
// -----------------------------------------------------------------------------
module tb_override_ctrl;

  localparam int HOLD_MIN = 4;
`ifdef OVERRIDE_CTRL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_val = 8'h00;
  logic [7:0] req_len = 8'd0;
  logic       rel_req = 1'b0;
  logic [7:0] tgt_q = 8'h00;
  logic       force_en;
  logic [7:0] force_val;
  logic       busy;
  logic       done;
  logic       err;

  int nChecks = 0;
  int nFail   = 0;
  bit checkEn = 1'b0;

  // Model state.
  logic       mReady   = 1'b1;
  logic       mForceEn = 1'b0;
  logic [7:0] mVal     = 8'h00;
  logic       mBusy    = 1'b0;
  logic       mDone    = 1'b0;
  logic       mErr     = 1'b0;
  int         mK       = 0;
  int         mTotal   = 0;

  // Monitors for the literal expectations.
  int   runLen     = 0;
  int   lastRunLen = 0;
  int   doneCount  = 0;
  logic prevEn     = 1'b0;

  override_ctrl #(.WIDTH(8), .HOLD_MIN(HOLD_MIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_val   (req_val),
    .req_len   (req_len),
    .rel_req   (rel_req),
    .tgt_q     (tgt_q),
    .force_en  (force_en),
    .force_val (force_val),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Counts one comparison. Any mismatch, including X, is reported as FAIL.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Drives all request-side inputs at once.
  task automatic applyStimulus(input logic valid, input logic [7:0] val,
                               input logic [7:0] len, input logic rel,
                               input logic [7:0] tgt);
    req_valid = valid;
    req_val   = val;
    req_len   = len;
    rel_req   = rel;
    tgt_q     = tgt;
  endtask

  // Advances n rising edges. Inputs change 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model. A request lasts max(len, HOLD_MIN) forced cycles,
  // or stops early when rel_req is seen in a forced cycle whose index is at
  // least HOLD_MIN. One done cycle follows, then the model is idle again.
  // Forced cycles with index 2 and up are hold cycles, and only those are
  // read back.
  always @(posedge clk) begin
    if (rst) begin
      mReady = 1'b1; mForceEn = 1'b0; mVal = 8'h00; mBusy = 1'b0;
      mDone = 1'b0; mErr = 1'b0; mK = 0;
    end else if (mDone) begin
      mDone = 1'b0; mBusy = 1'b0; mReady = 1'b1;
    end else if (mForceEn) begin
      if (CHECK_EN && mK >= 2 && tgt_q != mVal) mErr = 1'b1;
      if (mK == mTotal || (rel_req && mK >= HOLD_MIN)) begin
        mForceEn = 1'b0; mDone = 1'b1; mK = 0;
      end else begin
        mK = mK + 1;
      end
    end else if (mReady && req_valid) begin
      mVal    = req_val;
      mTotal  = (int'(req_len) < HOLD_MIN) ? HOLD_MIN : int'(req_len);
      mK      = 1;
      mForceEn = 1'b1; mReady = 1'b0; mBusy = 1'b1;
    end
  end

  // Compare process and monitors. These run on the edge away from the
  // active clock edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("req_ready", 32'(req_ready), 32'(mReady));
      checkOutput("force_en",  32'(force_en),  32'(mForceEn));
      checkOutput("force_val", 32'(force_val), 32'(mVal));
      checkOutput("busy",      32'(busy),      32'(mBusy));
      checkOutput("done",      32'(done),      32'(mDone));
      checkOutput("err",       32'(err),       32'(mErr));
      if (force_en === 1'b1) runLen++;
      if (prevEn === 1'b1 && force_en !== 1'b1) begin
        lastRunLen = runLen;
        runLen     = 0;
      end
      if (done === 1'b1) doneCount++;
      prevEn = force_en;
    end
  end

  initial begin : stimulus
    int d0;

    // Reset
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 8'h00);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_force_val", 32'(force_val), 32'h00);

    // Basic request: A5 for 6 cycles
    d0 = doneCount;
    applyStimulus(1'b1, 8'hA5, 8'd6, 1'b0, 8'hA5);
    tick(1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 8'hA5);
    checkOutput("basic_force_val", 32'(force_val), 32'hA5);
    tick(10);
    checkOutput("basic_len", 32'(lastRunLen), 32'd6);
    checkOutput("basic_done", 32'(doneCount - d0), 32'd1);

    // Short requests: len 0 and len 2 are both held for HOLD_MIN
    applyStimulus(1'b1, 8'h3C, 8'd0, 1'b0, 8'h3C);
    tick(1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 8'h3C);
    tick(8);
    checkOutput("len0_len", 32'(lastRunLen), 32'd4);
    applyStimulus(1'b1, 8'hC3, 8'd2, 1'b0, 8'hC3);
    tick(1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 8'hC3);
    tick(8);
    checkOutput("len2_len", 32'(lastRunLen), 32'd4);

    // Maximum length: 255 cycles, no wrap
    applyStimulus(1'b1, 8'h77, 8'd255, 1'b0, 8'h77);
    tick(1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 8'h77);
    tick(260);
    checkOutput("len255_len", 32'(lastRunLen), 32'd255);

    // Early release: rel_req at forced cycle 2 is ignored, at cycle 5 it
    // is honoured.
    d0 = doneCount;
    applyStimulus(1'b1, 8'h96, 8'd20, 1'b0, 8'h96);
    tick(1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 8'h96);
    tick(1);
    rel_req = 1'b1;
    tick(1);
    rel_req = 1'b0;
    tick(2);
    rel_req = 1'b1;
    tick(1);
    rel_req = 1'b0;
    tick(8);
    checkOutput("early_len", 32'(lastRunLen), 32'd5);
    checkOutput("early_done", 32'(doneCount - d0), 32'd1);

    // Reset at forced cycle 3
    d0 = doneCount;
    applyStimulus(1'b1, 8'hE1, 8'd10, 1'b0, 8'hE1);
    tick(1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 8'hE1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("rstmid_force_en", 32'(force_en), 32'd0);
    checkOutput("rstmid_force_val", 32'(force_val), 32'h00);
    checkOutput("rstmid_done", 32'(done), 32'd0);
    tick(3);
    checkOutput("rstmid_len", 32'(lastRunLen), 32'd3);
    checkOutput("rstmid_nodone", 32'(doneCount - d0), 32'd0);

    // Readback check: target reads 00 while 5A is forced
    applyStimulus(1'b1, 8'h5A, 8'd4, 1'b0, 8'h00);
    tick(1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 8'h00);
    tick(8);
    checkOutput("err_sticky", 32'(err), 32'(CHECK_EN));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("err_cleared", 32'(err), 32'd0);

    // Back-to-back requests with req_valid held high
    applyStimulus(1'b1, 8'h11, 8'd4, 1'b0, 8'h11);
    tick(1);
    req_val = 8'h22;
    tgt_q   = 8'h11;
    tick(4);
    checkOutput("b2b_done", 32'(done), 32'd1);
    checkOutput("b2b_val_hold", 32'(force_val), 32'h11);
    tick(1);
    checkOutput("b2b_ready", 32'(req_ready), 32'd1);
    checkOutput("b2b_val_idle", 32'(force_val), 32'h11);
    tgt_q = 8'h22;
    tick(1);
    checkOutput("b2b_second_en", 32'(force_en), 32'd1);
    checkOutput("b2b_second_val", 32'(force_val), 32'h22);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 8'h22);
    tick(8);
    checkOutput("b2b_second_len", 32'(lastRunLen), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/override_ctrl.md
OVERRIDE_CTRL -- requirements
Module: override_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of the forced value.
REQ-002 SHALL have parameter HOLD_MIN, default 4, the minimum number of forced cycles per request (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit, a force request offered.
REQ-006 SHALL have port req_ready, output, 1 bit, high when the controller accepts a request.
REQ-007 SHALL have port req_val, input, WIDTH bits, the value to force onto the target.
REQ-008 SHALL have port req_len, input, 8 bits, the requested hold length in cycles.
REQ-009 SHALL have port rel_req, input, 1 bit, an early release request.
REQ-010 SHALL have port tgt_q, input, WIDTH bits, the target register readback.
REQ-011 SHALL have port force_en, output, 1 bit, the override asserted on the target.
REQ-012 SHALL have port force_val, output, WIDTH bits, the value driven while force_en is high.
REQ-013 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit, a one-cycle pulse when the override is released.
REQ-015 SHALL have port err, output, 1 bit, a sticky readback mismatch flag.

Function
REQ-016 SHALL implement states IDLE, FORCE, HOLD and RELEASE, all outputs registered.
REQ-017 SHALL drive req_ready=1 only in IDLE; a handshake SHALL occur when req_valid and req_ready are both high at a rising edge.
REQ-018 SHALL, on handshake, latch req_val into force_val, set cnt = max(req_len, HOLD_MIN), and enter FORCE next cycle.
REQ-019 SHALL hold force_en=1 in FORCE and HOLD, and 0 in IDLE and RELEASE.
REQ-020 SHALL spend exactly one cycle in FORCE, then enter HOLD.
REQ-021 SHALL decrement cnt once per HOLD cycle and enter RELEASE when cnt reaches 1, giving exactly cnt cycles with force_en=1 in total (FORCE plus HOLD).
REQ-022 SHALL honour rel_req only after HOLD_MIN cycles of force_en=1 have elapsed, entering RELEASE on the next edge; earlier rel_req SHALL be ignored rather than queued.
REQ-023 SHALL pulse done=1 for the single RELEASE cycle, then return to IDLE.
REQ-024 SHALL keep force_val stable from handshake until the next handshake.
REQ-025 SHALL treat req_len=0 as HOLD_MIN, and req_len=255 as 255 cycles with no wrap.
REQ-026 SHALL ignore req_valid while busy; the request SHALL remain pending for the requester.
REQ-027 SHALL give an effective request-to-request turnaround of cnt+2 cycles, since req_ready returns one cycle after done.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, set state=IDLE, force_en=0, force_val=0, cnt=0, done=0, err=0, and req_ready=1 on the following cycle.
REQ-029 SHALL, on reset mid-override, drop force_en the next cycle without a done pulse.
REQ-030 SHALL give rst priority over req_valid and rel_req on the same edge.

Configuration
REQ-031 SHALL, with macro OVERRIDE_CTRL_CHECK_EN defined, compare tgt_q against force_val on every HOLD cycle and set err=1 on mismatch; err SHALL stay set until rst.
REQ-032 SHALL, without OVERRIDE_CTRL_CHECK_EN, tie err to constant 0 and not use tgt_q.

Verification
REQ-033 SHALL cover a basic request: req_val=8'hA5, req_len=6 -> force_en high 6 cycles, force_val=A5, done pulses once, req_ready back one cycle later.
REQ-034 SHALL cover a short request: req_len=0 and req_len=2 with HOLD_MIN=4 -> force_en high exactly 4 cycles each.
REQ-035 SHALL cover early release: req_len=20 with rel_req at forced cycle 2, then at cycle 5 -> first ignored, release after 5 forced cycles with done.
REQ-036 SHALL cover reset mid-HOLD: rst at forced cycle 3 -> force_en=0 next cycle, no done, force_val=0.
REQ-037 SHALL cover the readback check: with the macro defined, tgt_q=8'h00 while forcing 8'h5A -> err=1 sticky until rst; without the macro, err stays 0.
REQ-038 SHALL cover back-to-back requests: req_valid held high with two values -> second accepted only after done, and force_val changes only at the second handshake.
